// File: rtl/hpm_counter_bank_pkg.sv
// Shared definitions for the machine performance-monitor CSR bank:
// CSR write modes, address map, event ids and mhpmevent field layout.
package hpm_counter_bank_pkg;

  typedef enum logic [1:0] {
    CSR_WRITE = 2'd0,
    CSR_SET   = 2'd1,
    CSR_CLEAR = 2'd2
  } write_mode_t;

  // CSR addresses
  localparam logic [11:0] CSR_MCOUNTINHIBIT     = 12'h320;
  localparam logic [11:0] CSR_MHPMEVENT_BASE    = 12'h323;
  localparam logic [11:0] CSR_MHPMEVENT_LAST    = 12'h33F;
  localparam logic [11:0] CSR_MCYCLE            = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET          = 12'hB02;
  localparam logic [11:0] CSR_MHPMCOUNTER_BASE  = 12'hB03;
  localparam logic [11:0] CSR_MHPMCOUNTER_LAST  = 12'hB1F;
  localparam logic [11:0] CSR_HI_OFFSET         = 12'h080;

  // Event ids; id k is carried on events[k-1]
  localparam int EVT_LOAD      = 1;
  localparam int EVT_STORE     = 2;
  localparam int EVT_UNALIGNED = 3;
  localparam int EVT_ARITH     = 4;
  localparam int EVT_TRAP      = 5;
  localparam int EVT_IRQ       = 6;
  localparam int EVT_JUMP      = 7;
  localparam int EVT_BRANCH    = 8;
  localparam int EVT_TAKEN     = 9;

  // mhpmevent fields (SEL occupies the low EVT_SEL_W bits)
  localparam int MHPMEVENT_IE_BIT = 30;
  localparam int MHPMEVENT_OF_BIT = 31;

  // Low-half CSR address of counter slot k (0 = mcycle, 1 = minstret, 2.. = hpm3..)
  function automatic logic [11:0] cnt_lo_addr(input int k);
    if (k == 0) return CSR_MCYCLE;
    if (k == 1) return CSR_MINSTRET;
    return CSR_MHPMCOUNTER_BASE + 12'(k - 2);
  endfunction

endpackage

// File: rtl/hpm_counter_bank_counter.sv
// One performance counter: increments on inc, accepts 32-bit half writes,
// and flags a wrap from all-ones to zero. A write in the same cycle wins
// over the increment, so no wrap is reported then.
module hpm_counter #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         wr_lo,
  input  logic         wr_hi,
  input  logic [31:0]  wdata,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  logic [W-1:0] cnt_q, cnt_d;

  // next count: half write, otherwise optional increment
  always_comb begin
    cnt_d = cnt_q;
    wrap  = 1'b0;
    if (wr_lo) begin
      cnt_d[31:0] = wdata;
    end else if (wr_hi) begin
      cnt_d[W-1:32] = wdata[W-33:0];
    end else if (inc) begin
      cnt_d = cnt_q + W'(1);
      wrap  = &cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hpm_counter_bank.sv
// Machine performance-monitor CSR bank: mcycle, minstret, NUM_HPM
// event-selected counters with sticky overflow flags, mcountinhibit,
// and a registered overflow interrupt.
module hpm_counter_bank
  import hpm_counter_bank_pkg::*;
#(
  parameter int NUM_HPM       = 4,
  parameter int COUNTER_WIDTH = 64,
  parameter int NUM_EVENTS    = 9,
  parameter int EVT_SEL_W     = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [11:0]           addr,
  input  logic                  wr,
  input  write_mode_t           write_mode,
  input  logic [31:0]           din,
  output logic [31:0]           dout,
  output logic                  illegal_address,
  input  logic                  retire,
  input  logic [NUM_EVENTS-1:0] events,
  output logic                  overflow_irq
);

  localparam int NUM_CNT = NUM_HPM + 2;
  // implemented mcountinhibit bits: CY, IR and one per hpm counter
  localparam logic [31:0] INH_MASK = 32'h5 | (((32'd1 << NUM_HPM) - 32'd1) << 3);

  logic [31:0]              inhibit_q, inhibit_d;
  logic [EVT_SEL_W-1:0]     sel_q [NUM_HPM];
  logic [EVT_SEL_W-1:0]     sel_d [NUM_HPM];
  logic [NUM_HPM-1:0]       ie_q, ie_d, of_q, of_d;
  logic                     irq_q, irq_d;

  logic [COUNTER_WIDTH-1:0] cnt [NUM_CNT];
  logic [NUM_CNT-1:0]       inc, wrap, wr_lo, wr_hi;
  logic [NUM_HPM-1:0]       wr_evt;
  logic                     wr_inh;
  logic                     legal;
  logic [31:0]              rd_data, wdata;

  // address decode: read mux, legality and per-register write enables
  always_comb begin
    logic [63:0] cnt_ext;
    logic [31:0] evt_word;
    rd_data  = '0;
    wr_inh   = 1'b0;
    wr_evt   = '0;
    wr_lo    = '0;
    wr_hi    = '0;
    cnt_ext  = '0;
    evt_word = '0;
    legal = (addr == CSR_MCOUNTINHIBIT)
         || (addr >= CSR_MHPMEVENT_BASE && addr <= CSR_MHPMEVENT_LAST)
         || (addr == CSR_MCYCLE) || (addr == CSR_MINSTRET)
         || (addr == (CSR_MCYCLE | CSR_HI_OFFSET))
         || (addr == (CSR_MINSTRET | CSR_HI_OFFSET))
         || (addr >= CSR_MHPMCOUNTER_BASE && addr <= CSR_MHPMCOUNTER_LAST)
         || (addr >= (CSR_MHPMCOUNTER_BASE | CSR_HI_OFFSET)
             && addr <= (CSR_MHPMCOUNTER_LAST | CSR_HI_OFFSET));
    if (addr == CSR_MCOUNTINHIBIT) begin
      rd_data = inhibit_q;
      wr_inh  = wr;
    end
    // slots beyond NUM_HPM match nothing here: they read 0 and drop writes
    for (int i = 0; i < NUM_HPM; i++) begin
      if (addr == CSR_MHPMEVENT_BASE + 12'(i)) begin
        evt_word                    = '0;
        evt_word[EVT_SEL_W-1:0]     = sel_q[i];
        evt_word[MHPMEVENT_IE_BIT]  = ie_q[i];
        evt_word[MHPMEVENT_OF_BIT]  = of_q[i];
        rd_data   = evt_word;
        wr_evt[i] = wr;
      end
    end
    for (int k = 0; k < NUM_CNT; k++) begin
      cnt_ext = 64'(cnt[k]);
      if (addr == cnt_lo_addr(k)) begin
        rd_data  = cnt_ext[31:0];
        wr_lo[k] = wr;
      end
      if (addr == (cnt_lo_addr(k) | CSR_HI_OFFSET)) begin
        rd_data  = cnt_ext[63:32];
        wr_hi[k] = wr;
      end
    end
  end

  // write operand from the CSR operation applied to the current read value
  always_comb begin
    case (write_mode)
      CSR_WRITE: wdata = din;
      CSR_SET:   wdata = rd_data | din;
      CSR_CLEAR: wdata = rd_data & ~din;
      default:   wdata = rd_data;
    endcase
  end

  // increment conditions for every counter slot
  always_comb begin
    logic hit;
    hit    = 1'b0;
    inc    = '0;
    inc[0] = ~inhibit_q[0];
    inc[1] = retire & ~inhibit_q[2];
    for (int i = 0; i < NUM_HPM; i++) begin
      hit = 1'b0;
      for (int k = 1; k <= NUM_EVENTS; k++) begin
        if (sel_q[i] == EVT_SEL_W'(k) && events[k-1]) hit = 1'b1;
      end
      inc[2+i] = hit & ~inhibit_q[3+i];
    end
  end

  // next state of inhibit, event selectors, sticky flags and interrupt
  always_comb begin
    inhibit_d = wr_inh ? (wdata & INH_MASK) : inhibit_q;
    sel_d     = sel_q;
    ie_d      = ie_q;
    of_d      = of_q;
    for (int i = 0; i < NUM_HPM; i++) begin
      of_d[i] = of_q[i] | wrap[2+i];
      if (wr_evt[i]) begin
        sel_d[i] = wdata[EVT_SEL_W-1:0];
        ie_d[i]  = wdata[MHPMEVENT_IE_BIT];
        // a wrap on the same edge must not be lost to the write
        of_d[i]  = wdata[MHPMEVENT_OF_BIT] | wrap[2+i];
      end
    end
    irq_d = |(of_q & ie_q);
  end

  // control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      inhibit_q <= '0;
      for (int i = 0; i < NUM_HPM; i++) sel_q[i] <= '0;
      ie_q      <= '0;
      of_q      <= '0;
      irq_q     <= 1'b0;
    end else begin
      inhibit_q <= inhibit_d;
      sel_q     <= sel_d;
      ie_q      <= ie_d;
      of_q      <= of_d;
      irq_q     <= irq_d;
    end
  end

  for (genvar k = 0; k < NUM_CNT; k++) begin : g_cnt
    hpm_counter #(.W(COUNTER_WIDTH)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (inc[k]),
      .wr_lo (wr_lo[k]),
      .wr_hi (wr_hi[k]),
      .wdata (wdata),
      .cnt   (cnt[k]),
      .wrap  (wrap[k])
    );
  end

  assign dout            = rd_data;
  assign illegal_address = ~legal;
  assign overflow_irq    = irq_q;

endmodule

// File: tb/tb_hpm_counter_bank.sv
// Directed bench for hpm_counter_bank (NUM_HPM=4, COUNTER_WIDTH=40).
// Expected values are queued when a read is issued and popped when the
// combinational response is sampled.
module tb_hpm_counter_bank;
  import hpm_counter_bank_pkg::*;

  logic        clk;
  logic        rst;
  logic [11:0] addr;
  logic        wr;
  write_mode_t write_mode;
  logic [31:0] din;
  logic [31:0] dout;
  logic        illegal_address;
  logic        retire;
  logic [8:0]  events;
  logic        overflow_irq;

  int checks   = 0;
  int failures = 0;
  int mc;

  string       tag_q[$];
  logic [32:0] exp_q[$];

  hpm_counter_bank #(
    .NUM_HPM(4), .COUNTER_WIDTH(40), .NUM_EVENTS(9), .EVT_SEL_W(5)
  ) dut (
    .clk(clk), .rst(rst), .addr(addr), .wr(wr), .write_mode(write_mode),
    .din(din), .dout(dout), .illegal_address(illegal_address),
    .retire(retire), .events(events), .overflow_irq(overflow_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  function automatic logic [8:0] evt(input int id);
    logic [8:0] one;
    one = 9'd1;
    return one << (id - 1);
  endfunction

  // read: queue expectation, drive addr, sample combinational result, advance one cycle
  task automatic rd(input string tag, input logic [11:0] a,
                    input logic [31:0] exp_d, input logic exp_ill);
    string       t;
    logic [32:0] e;
    tag_q.push_back(tag);
    exp_q.push_back({exp_ill, exp_d});
    addr = a;
    #1;
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    checks++;
    assert (dout === e[31:0]) else begin
      failures++;
      $error("FAIL %s dout got=%h want=%h", t, dout, e[31:0]);
    end
    checks++;
    assert (illegal_address === e[32]) else begin
      failures++;
      $error("FAIL %s illegal_address got=%b want=%b", t, illegal_address, e[32]);
    end
    @(negedge clk);
  endtask

  // interrupt check without advancing the clock
  task automatic chk_irq(input string tag, input logic exp_irq);
    string       t;
    logic [32:0] e;
    tag_q.push_back(tag);
    exp_q.push_back({32'd0, exp_irq});
    #1;
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    checks++;
    assert (overflow_irq === e[0]) else begin
      failures++;
      $error("FAIL %s overflow_irq got=%b want=%b", t, overflow_irq, e[0]);
    end
  endtask

  // CSR write spanning exactly one rising edge
  task automatic csr_wr(input logic [11:0] a, input write_mode_t m, input logic [31:0] d);
    addr       = a;
    write_mode = m;
    din        = d;
    wr         = 1'b1;
    @(negedge clk);
    wr         = 1'b0;
  endtask

  initial begin
    rst = 1'b1; addr = '0; wr = 1'b0; write_mode = CSR_WRITE; din = '0;
    retire = 1'b0; events = '0;
    repeat (3) @(negedge clk);

    // reset state
    chk_irq("rst_irq", 1'b0);
    rd("rst_mcycle", 12'hB00, 32'd0, 1'b0);
    rd("rst_evt3", 12'h323, 32'd0, 1'b0);
    rst = 1'b0;

    // free-running mcycle
    repeat (10) @(negedge clk);
    mc = 10;
    rd("mcycle_10", 12'hB00, mc, 1'b0);              mc++;
    rd("mcycleh_0", 12'hB80, 32'd0, 1'b0);           mc++;
    rd("minstret_0", 12'hB02, 32'd0, 1'b0);          mc++;

    // inhibit mcycle, then resume
    csr_wr(12'h320, CSR_WRITE, 32'h1);               mc++;
    repeat (5) @(negedge clk);
    rd("mcycle_inh", 12'hB00, mc, 1'b0);
    rd("inhibit_rd", 12'h320, 32'h1, 1'b0);
    csr_wr(12'h320, CSR_CLEAR, 32'h1);
    rd("mcycle_resume0", 12'hB00, mc, 1'b0);         mc++;
    rd("mcycle_resume1", 12'hB00, mc, 1'b0);

    // minstret counts retire
    retire = 1'b1;
    repeat (3) @(negedge clk);
    retire = 1'b0;
    rd("minstret_3", 12'hB02, 32'd3, 1'b0);

    // event selection: only the selected event counts
    csr_wr(12'h323, CSR_WRITE, 32'(EVT_STORE));
    for (int n = 0; n < 7; n++) begin
      events = evt(EVT_LOAD);
      @(negedge clk);
      events = evt(EVT_STORE);
      @(negedge clk);
    end
    events = '0;
    rd("hpm3_7", 12'hB03, 32'd7, 1'b0);
    rd("hpm4_0", 12'hB04, 32'd0, 1'b0);
    rd("evt3_sel", 12'h323, 32'd2, 1'b0);

    // 40-bit wrap, sticky OF and interrupt
    csr_wr(12'hB83, CSR_WRITE, 32'hFF);
    csr_wr(12'hB03, CSR_WRITE, 32'hFFFF_FFFF);
    csr_wr(12'h323, CSR_WRITE, 32'h4000_0001);
    rd("hpm3h_ff", 12'hB83, 32'hFF, 1'b0);
    rd("hpm3_ones", 12'hB03, 32'hFFFF_FFFF, 1'b0);
    events = evt(EVT_LOAD);
    @(negedge clk);
    events = '0;
    chk_irq("irq_not_yet", 1'b0);
    rd("hpm3_wrapped", 12'hB03, 32'd0, 1'b0);
    chk_irq("irq_set", 1'b1);
    rd("hpm3h_wrapped", 12'hB83, 32'd0, 1'b0);
    rd("evt3_of", 12'h323, 32'hC000_0001, 1'b0);
    csr_wr(12'h323, CSR_CLEAR, 32'h8000_0000);
    chk_irq("irq_hold", 1'b1);
    @(negedge clk);
    chk_irq("irq_drop", 1'b0);
    rd("evt3_ofclr", 12'h323, 32'h4000_0001, 1'b0);

    // write beats same-cycle increment
    events = evt(EVT_LOAD);
    csr_wr(12'hB03, CSR_WRITE, 32'h100);
    events = '0;
    rd("wr_wins", 12'hB03, 32'h100, 1'b0);
    events = evt(EVT_LOAD);
    @(negedge clk);
    events = '0;
    rd("inc_after_wr", 12'hB03, 32'h101, 1'b0);

    // per-counter inhibit and hardwired inhibit bits
    csr_wr(12'h320, CSR_WRITE, 32'hFFFF_FFFF);
    rd("inhibit_mask", 12'h320, 32'h7D, 1'b0);
    csr_wr(12'h320, CSR_WRITE, 32'h8);
    events = evt(EVT_LOAD);
    repeat (2) @(negedge clk);
    events = '0;
    rd("hpm3_inhibited", 12'hB03, 32'h101, 1'b0);
    csr_wr(12'h320, CSR_WRITE, 32'h0);

    // event write on the same edge as a wrap keeps OF
    csr_wr(12'hB84, CSR_WRITE, 32'hFF);
    csr_wr(12'hB04, CSR_WRITE, 32'hFFFF_FFFF);
    csr_wr(12'h324, CSR_WRITE, 32'(EVT_UNALIGNED));
    events = evt(EVT_UNALIGNED);
    csr_wr(12'h324, CSR_WRITE, 32'h5);
    events = '0;
    rd("evt4_wr_wrap", 12'h324, 32'h8000_0005, 1'b0);
    rd("hpm4_wrapped", 12'hB04, 32'd0, 1'b0);
    rd("hpm4h_wrapped", 12'hB84, 32'd0, 1'b0);

    // SEL above NUM_EVENTS never counts
    csr_wr(12'h324, CSR_WRITE, 32'd10);
    events = '1;
    repeat (2) @(negedge clk);
    events = '0;
    rd("sel_oob", 12'hB04, 32'd0, 1'b0);
    rd("sel_all_ev", 12'hB03, 32'h103, 1'b0);

    // illegal and unimplemented addresses
    rd("ill_b01", 12'hB01, 32'd0, 1'b1);
    rd("ill_321", 12'h321, 32'd0, 1'b1);
    rd("ill_322", 12'h322, 32'd0, 1'b1);
    rd("ill_b81", 12'hB81, 32'd0, 1'b1);
    rd("ill_c00", 12'hC00, 32'd0, 1'b1);
    rd("unimp_33f", 12'h33F, 32'd0, 1'b0);
    csr_wr(12'h33F, CSR_WRITE, 32'hFFFF_FFFF);
    rd("unimp_33f_wr", 12'h33F, 32'd0, 1'b0);
    csr_wr(12'h327, CSR_WRITE, 32'h5);
    rd("unimp_327_wr", 12'h327, 32'd0, 1'b0);
    rd("unimp_b1f", 12'hB1F, 32'd0, 1'b0);
    rd("unimp_b9f", 12'hB9F, 32'd0, 1'b0);

    // reset overrides a concurrent write
    csr_wr(12'h323, CSR_WRITE, 32'hC000_0001);
    addr = 12'hB03; din = 32'h55; write_mode = CSR_WRITE; wr = 1'b1; rst = 1'b1;
    @(negedge clk);
    wr = 1'b0; rst = 1'b0;
    rd("rst_mid_hpm3", 12'hB03, 32'd0, 1'b0);
    rd("rst_mid_evt3", 12'h323, 32'd0, 1'b0);
    chk_irq("rst_mid_irq", 1'b0);
    rd("rst_mid_inh", 12'h320, 32'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hpm_counter_bank.md
Name:
hpm_counter_bank

Overview:
Parametrised machine performance-monitor CSR bank: mcycle, minstret, NUM_HPM event-driven mhpmcounters, mhpmevent selectors and mcountinhibit.
Adds true per-counter inhibit, event-vector selection, writable counters, sticky overflow flags and an overflow interrupt.
Sits beside the other CSR units in the core's CSR decode path. Shares the addr/wr/write_mode/din/dout/illegal_address convention.

Parameters:
NUM_HPM, 4, number of implemented mhpmcounter/mhpmevent pairs (1..29), indices 3..3+NUM_HPM-1
COUNTER_WIDTH, 64, implemented bits per counter (33..64); bits above read 0
NUM_EVENTS, 9, width of event input vector
EVT_SEL_W, 5, width of event-select field in mhpmevent

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
addr  in  12  CSR address
wr  in  1  CSR write strobe
write_mode  in  write_mode_t  CSR_WRITE / CSR_SET / CSR_CLEAR
din  in  32  CSR write operand
dout  out  32  CSR read data (combinational)
illegal_address  out  1  addr not handled by this block (combinational)
retire  in  1  one instruction retired this cycle
events  in  NUM_EVENTS  per-cycle event pulses; bit k = event id k+1
overflow_irq  out  1  registered OR over (OF & IE) of all HPM counters

Behaviour:
- Reset: all counters 0, mcountinhibit 0, all mhpmevent 0, overflow_irq 0. dout/illegal_address follow addr.
- mcountinhibit: bit0 gates mcycle, bit2 gates minstret, bit(3+i) gates hpm i. Bit1 and unimplemented bits are hardwired 0.
- mhpmevent[i] fields:
  - [EVT_SEL_W-1:0] SEL.
  - bit30 IE, overflow interrupt enable.
  - bit31 OF, sticky overflow flag.
  - Other bits read 0.
- Increment, +1 per cycle when not inhibited:
  - mcycle: every cycle.
  - minstret: when retire=1.
  - hpm i: when SEL in 1..NUM_EVENTS and events[SEL-1]=1. SEL 0 or SEL>NUM_EVENTS never counts.
- Wrap: a counter at all-ones (COUNTER_WIDTH) that increments becomes 0. For hpm i this sets OF[i] in the same edge. mcycle/minstret have no flag.
- Write data: CSR_WRITE: din. CSR_SET: cur|din. CSR_CLEAR: cur&~din, where cur is the current read value at addr.
- Write commits at posedge when wr=1 and the address is legal. Writes to illegal addresses have no effect.
- Counter write vs increment on the same edge: the write wins and that cycle's increment is dropped.
  - Low-half write leaves upper bits unchanged; high-half write leaves low 32 unchanged.
  - High-half bits above COUNTER_WIDTH are discarded.
- mhpmevent write on the same edge as a wrap of that counter: new OF = written OF | 1. SEL/IE are taken from the write.
- Reads are combinational and return the pre-edge value.
- overflow_irq is registered: it asserts the cycle after OF&IE first becomes true and deasserts the cycle after software clears OF or IE.
- Address map: 0x320 mcountinhibit; 0x323..0x33F mhpmevent3..31; 0xB00 / 0xB80 mcycle lo/hi; 0xB02 / 0xB82 minstret lo/hi; 0xB03..0xB1F / 0xB83..0xB9F mhpmcounter3..31 lo/hi.
- Indices 3..31 beyond NUM_HPM are legal: they read 0 and ignore writes.
- illegal_address=1 for all other addresses, including 0x321, 0x322, 0xB01 and 0xB81; dout=0 then.
- Reset asserted mid-operation overrides any write or increment on that edge.

Decomposition:
- global_pkg gains:
  - CSR address constants (CSR_MCOUNTINHIBIT, CSR_MHPMEVENT_BASE, CSR_MCYCLE, CSR_MINSTRET, CSR_MHPMCOUNTER_BASE, hi-half offset 0x80).
  - Event-id constants (EVT_LOAD=1, EVT_STORE=2, EVT_UNALIGNED=3, EVT_ARITH=4, EVT_TRAP=5, EVT_IRQ=6, EVT_JUMP=7, EVT_BRANCH=8, EVT_TAKEN=9).
  - mhpmevent field positions.
- Sub-module hpm_counter: one COUNTER_WIDTH counter with inc, lo/hi write enables, write data and wrap pulse output.
- The bank instantiates NUM_HPM+2 hpm_counter copies via generate.

Test Plan:
1. Reset, then idle 10 cycles -> read 0xB00 = 10, 0xB80 = 0, 0xB02 = 0; illegal_address=0 on all three.
2. Write 0x320=0x1, wait 5 cycles, read 0xB00 -> unchanged value; CSR_CLEAR din=0x1 -> counting resumes next cycle.
3. Write 0x323 SEL=2; pulse events[1] 7 times interleaved with events[0] pulses -> 0xB03 = 7, 0xB04 = 0.
4. COUNTER_WIDTH=40: write 0xB83=0xFF, 0xB03=0xFFFFFFFF, IE=1, SEL=1; one events[0] pulse -> counter 0, OF=1, overflow_irq=1 one cycle later. Clear OF -> irq drops next cycle.
5. Write 0xB03=0x100 in the same cycle as a selected event pulse -> reads 0x100, not 0x101.
6. Read 0xB01, 0x321, 0xC00 -> illegal_address=1, dout=0. Read 0x33F with NUM_HPM=4 -> illegal_address=0, dout=0; writes there have no effect.
